icache_assoc_datapath: RTL and testbench
========================================

// Module: icache_assoc_datapath
// PURPOSE
//  N-way set-associative instruction-cache datapath; generalised successor of the direct-mapped icache datapath.
//  Sits between instruction fetch and the icache controller/memory refill path: tag compare across all ways,
//  word select, refill into a victim way, multi-cycle set-walking flush. Refill sequencing stays in the controller.
// PARAMETERS
//  ADDR_WIDTH   32   fetch/memory byte-address width
//  DATA_WIDTH   32   fetch word width (bits)
//  LINE_WIDTH   128  cache line width (bits); LINE_WIDTH/DATA_WIDTH is a power of 2
//  NO_OF_SETS   64   sets; power of 2, >=2
//  NO_OF_WAYS   2    ways; 1, 2, 4 or 8 (1 = direct-mapped)
// PORTS
//  clk_i              in   1           clock, all state on posedge
//  rst_i              in   1           synchronous active-high reset
//  lookup_req_i       in   1           fetch lookup valid this cycle
//  addr_i             in   ADDR_WIDTH  fetch byte address (lookup and refill)
//  hit_o              out  1           comb: lookup hit this cycle
//  rdata_o            out  DATA_WIDTH  registered fetch word
//  rdata_valid_o      out  1           registered: rdata_o valid (1-cycle pulse)
//  refill_i           in   1           write refill_data_i as line for addr_i
//  refill_data_i      in   LINE_WIDTH  line from memory
//  icache2mem_addr_o  out  ADDR_WIDTH  line-aligned addr_i (offset bits zeroed)
//  flush_i            in   1           start full invalidate
//  flush_busy_o       out  1           flush walk in progress
// BEHAVIOUR
//  Addr split: OFFSET_BITS=log2(LINE_WIDTH/8); index=addr_i[OFFSET_BITS+IDX_BITS-1:OFFSET_BITS]; tag=upper bits;
//   word=addr_i[OFFSET_BITS-1:log2(DATA_WIDTH/8)].
//  Lookup: hit_o = lookup_req_i & ~flush_busy_o & any way (valid & tag match). At most one way matches.
//  Latency 1: on hit, next cycle rdata_o = selected word of hit way, rdata_valid_o=1; otherwise rdata_valid_o=0,
//   rdata_o holds its last value.
//  Arrays read-before-write: lookup and refill of the same line in one cycle -> hit_o=0 that cycle, hit next cycle.
//  Victim: lowest-index invalid way in set; if all valid, per-set round-robin pointer rr[set] (IDX resets to 0).
//   rr[set] advances (mod NO_OF_WAYS) only when a refill evicts a valid line. Hits do not touch rr.
//  Refill (refill_i & ~flush_busy_o): victim way <- {valid=1, tag, refill_data_i}. Single-cycle, no ack.
//   refill_i while flush_busy_o is dropped. Refill of an already-present tag is a controller error (not checked).
//  Flush FSM: IDLE, FLUSH. IDLE --flush_i--> FLUSH, cnt=0. FLUSH: clear valid of all ways and rr at set cnt,
//   cnt++; at cnt==NO_OF_SETS-1 -> IDLE. Takes NO_OF_SETS cycles. flush_i while in FLUSH ignored.
//   flush_busy_o = (state==FLUSH). Data array never cleared.
//  Reset: rst_i -> state=FLUSH, cnt=0, rdata_o=0, rdata_valid_o=0; first cycle after rst_i low flush_busy_o=1,
//   hit_o=0; cache usable after NO_OF_SETS cycles. rst_i mid-flush restarts the walk at set 0.
//  Priority per cycle: rst_i > flush walk > refill > lookup data register.
//  icache2mem_addr_o = {addr_i[ADDR_WIDTH-1:OFFSET_BITS], '0}; purely combinational.
// STRUCTURE
//  cache_defs package: derived widths (OFFSET/IDX/TAG/WORD_SEL bits), flush state enum type_icache_flush_e.
//  Arrays: per-way tag+valid and per-way data line, packed arrays indexed [way][set]; rr[set] array.
//  Sub-module icache_victim_sel: per-set valid vector + rr -> one-hot victim way; owns rr update/clear.
// TESTING (NO_OF_WAYS=2, NO_OF_SETS=64, LINE_WIDTH=128 unless stated)
//  Reset: rst_i 1 cycle -> flush_busy_o=1 exactly 64 cycles; lookup 0x1040 during/after -> hit_o=0.
//  Refill 0x1040, data {4x44444444,4x33333333..} words w3..w0=4444..,3333..,2222..,1111.. -> next cycle
//   lookup 0x1048 hit_o=1, following cycle rdata_o=0x33333333, rdata_valid_o=1; icache2mem_addr_o=0x1040 for 0x104C.
//  Conflict in set 4: refill 0x1040, 0x2040 (both hit), 0x3040 evicts 0x1040, 0x4040 evicts 0x2040; 0x3040 and
//   0x4040 hit, 0x1040 and 0x2040 miss.
//  Flush after fills: flush_i 1 cycle -> 64 busy cycles, hit_o=0, refill_i pulses ignored; then all lines miss,
//   next refill in set 4 lands in way0.
//  Same-cycle refill+lookup of 0x1040 -> hit_o=0 that cycle, 1 the next; rst_i at flush cycle 30 -> 64 more busy.
//  NO_OF_WAYS=1: refill 0x1040 then 0x2040 -> 0x1040 misses, 0x2040 hits.

Source files
------------

// File: rtl/icache_assoc_datapath_pkg.sv
// Shared definitions for the set-associative icache datapath: flush FSM state type
// and helpers deriving address-field widths from the cache geometry.
package icache_assoc_datapath_pkg;

  typedef enum logic {
    FLUSH_IDLE = 1'b0,
    FLUSH_WALK = 1'b1
  } type_icache_flush_e;

  function automatic int unsigned offset_bits(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned no_of_sets);
    return $clog2(no_of_sets);
  endfunction

  function automatic int unsigned byte_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_width,
                                           input int unsigned line_width,
                                           input int unsigned no_of_sets);
    return addr_width - offset_bits(line_width) - idx_bits(no_of_sets);
  endfunction

  function automatic int unsigned wsel_bits(input int unsigned line_width,
                                            input int unsigned data_width);
    return offset_bits(line_width) - byte_bits(data_width);
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selection: lowest invalid way of the set, else the per-set round-robin
// pointer, which advances only on an eviction and is cleared by the flush walk.
module icache_victim_sel
  import icache_assoc_datapath_pkg::*;
#(
  parameter int unsigned NO_OF_WAYS = 2,
  parameter int unsigned NO_OF_SETS = 64
) (
  input  logic                           clk_i,
  input  logic [NO_OF_WAYS-1:0]          set_valid_i,
  input  logic [idx_bits(NO_OF_SETS)-1:0] set_idx_i,
  input  logic                           refill_en_i,
  input  logic                           flush_clr_i,
  input  logic [idx_bits(NO_OF_SETS)-1:0] flush_idx_i,
  output logic [NO_OF_WAYS-1:0]          victim_oh_c_o
);

  localparam int unsigned RR_BITS = (NO_OF_WAYS > 1) ? $clog2(NO_OF_WAYS) : 1;

  logic [NO_OF_SETS-1:0][RR_BITS-1:0] rr_q;
  logic [RR_BITS-1:0]                 rr_cur;
  logic [RR_BITS-1:0]                 rr_nxt;
  logic                               all_valid;
  logic                               found;

  assign rr_cur    = rr_q[set_idx_i];
  assign all_valid = &set_valid_i;
  assign rr_nxt    = (rr_cur == RR_BITS'(NO_OF_WAYS - 1)) ? '0 : rr_cur + RR_BITS'(1);

  always_comb begin
    victim_oh_c_o = '0;
    found         = 1'b0;
    for (int w = 0; w < NO_OF_WAYS; w++) begin
      if (!set_valid_i[w] && !found) begin
        victim_oh_c_o[w] = 1'b1;
        found            = 1'b1;
      end
    end
    if (!found) begin
      victim_oh_c_o = NO_OF_WAYS'(1) << rr_cur;
    end
  end

  // Pointer storage needs no reset: the reset-initiated flush walk clears every set.
  always_ff @(posedge clk_i) begin
    if (flush_clr_i) begin
      rr_q[flush_idx_i] <= '0;
    end else if (refill_en_i && all_valid) begin
      rr_q[set_idx_i] <= rr_nxt;
    end
  end

endmodule

// File: rtl/icache_assoc_datapath.sv
// N-way set-associative icache datapath: parallel tag compare, registered word select,
// victim-way refill and a one-set-per-cycle invalidate walk.
module icache_assoc_datapath
  import icache_assoc_datapath_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned NO_OF_SETS = 64,
  parameter int unsigned NO_OF_WAYS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lookup_req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  input  logic                  refill_i,
  input  logic [LINE_WIDTH-1:0] refill_data_i,
  output logic [ADDR_WIDTH-1:0] icache2mem_addr_o,
  input  logic                  flush_i,
  output logic                  flush_busy_o
);

  localparam int unsigned OFFSET_BITS = offset_bits(LINE_WIDTH);
  localparam int unsigned IDX_BITS    = idx_bits(NO_OF_SETS);
  localparam int unsigned TAG_BITS    = tag_bits(ADDR_WIDTH, LINE_WIDTH, NO_OF_SETS);
  localparam int unsigned BYTE_BITS   = byte_bits(DATA_WIDTH);
  localparam int unsigned WSEL_BITS   = wsel_bits(LINE_WIDTH, DATA_WIDTH);
  localparam int unsigned WORDS       = LINE_WIDTH / DATA_WIDTH;

  logic [NO_OF_WAYS-1:0][NO_OF_SETS-1:0]                 valid_q;
  logic [NO_OF_WAYS-1:0][NO_OF_SETS-1:0][TAG_BITS-1:0]   tag_q;
  logic [NO_OF_WAYS-1:0][NO_OF_SETS-1:0][LINE_WIDTH-1:0] data_q;

  type_icache_flush_e    state_q;
  logic [IDX_BITS-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rdata_valid_q;

  logic [IDX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   tag;
  logic [WSEL_BITS-1:0]  wsel;
  logic                  flush_busy;
  logic                  hit_c;
  logic                  refill_en;
  logic [NO_OF_WAYS-1:0] set_valid;
  logic [NO_OF_WAYS-1:0] way_hit;
  logic [NO_OF_WAYS-1:0] victim_oh;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [WORDS-1:0][DATA_WIDTH-1:0] line_words;
  logic                  unused_byte_bits;

  assign idx  = addr_i[OFFSET_BITS +: IDX_BITS];
  assign tag  = addr_i[ADDR_WIDTH-1 -: TAG_BITS];
  assign wsel = addr_i[BYTE_BITS +: WSEL_BITS];
  assign unused_byte_bits = ^addr_i[BYTE_BITS-1:0];

  assign flush_busy        = (state_q == FLUSH_WALK);
  assign flush_busy_o      = flush_busy;
  assign icache2mem_addr_o = {addr_i[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};

  // Tag compare across all ways of the indexed set; at most one way can match.
  always_comb begin
    set_valid  = '0;
    way_hit    = '0;
    hit_word   = '0;
    line_words = '0;
    for (int w = 0; w < NO_OF_WAYS; w++) begin
      set_valid[w] = valid_q[w][idx];
      way_hit[w]   = valid_q[w][idx] && (tag_q[w][idx] == tag);
      if (way_hit[w]) begin
        line_words = data_q[w][idx];
        hit_word   = hit_word | line_words[wsel];
      end
    end
  end

  assign hit_c     = lookup_req_i && !flush_busy && (|way_hit);
  assign hit_o     = hit_c;
  assign refill_en = refill_i && !flush_busy && !rst_i;

  icache_victim_sel #(
    .NO_OF_WAYS (NO_OF_WAYS),
    .NO_OF_SETS (NO_OF_SETS)
  ) u_victim_sel (
    .clk_i         (clk_i),
    .set_valid_i   (set_valid),
    .set_idx_i     (idx),
    .refill_en_i   (refill_en),
    .flush_clr_i   (flush_busy),
    .flush_idx_i   (cnt_q),
    .victim_oh_c_o (victim_oh)
  );

  // Flush walk FSM and registered fetch-word output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= FLUSH_WALK;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= hit_c;
      if (hit_c) begin
        rdata_q <= hit_word;
      end
      case (state_q)
        FLUSH_IDLE: begin
          if (flush_i) begin
            state_q <= FLUSH_WALK;
            cnt_q   <= '0;
          end
        end
        FLUSH_WALK: begin
          cnt_q <= cnt_q + IDX_BITS'(1);
          if (cnt_q == IDX_BITS'(NO_OF_SETS - 1)) begin
            state_q <= FLUSH_IDLE;
          end
        end
        default: state_q <= FLUSH_IDLE;
      endcase
    end
  end

  // Arrays are read before written, so a same-cycle refill is visible only next cycle.
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < NO_OF_WAYS; w++) begin
      if (flush_busy) begin
        valid_q[w][cnt_q] <= 1'b0;
      end else if (refill_en && victim_oh[w]) begin
        valid_q[w][idx] <= 1'b1;
        tag_q[w][idx]   <= tag;
        data_q[w][idx]  <= refill_data_i;
      end
    end
  end

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;

endmodule

// File: tb/tb_icache_assoc_datapath.sv
// Directed bench for the set-associative icache datapath (2-way main instance plus a
// direct-mapped instance sharing the stimulus); fetch words are scoreboarded.
module tb_icache_assoc_datapath;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         lookup_req_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic         refill_i = 1'b0;
  logic [127:0] refill_data_i = '0;
  logic         flush_i = 1'b0;

  logic         hit_o, rdata_valid_o, flush_busy_o;
  logic [31:0]  rdata_o, icache2mem_addr_o;
  logic         hit1, rdata_valid1, flush_busy1;
  logic [31:0]  rdata1, icache2mem_addr1;

  int n_vec = 0;
  int n_err = 0;
  int n_busy;
  logic [31:0] exp_q[$];

  localparam logic [127:0] SPEC_LINE = 128'h44444444_33333333_22222222_11111111;

  always #5 clk = ~clk;

  icache_assoc_datapath #(.NO_OF_WAYS(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .lookup_req_i(lookup_req_i), .addr_i(addr_i),
    .hit_o(hit_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .refill_i(refill_i), .refill_data_i(refill_data_i),
    .icache2mem_addr_o(icache2mem_addr_o), .flush_i(flush_i), .flush_busy_o(flush_busy_o)
  );

  icache_assoc_datapath #(.NO_OF_WAYS(1)) dut_dm (
    .clk_i(clk), .rst_i(rst_i), .lookup_req_i(lookup_req_i), .addr_i(addr_i),
    .hit_o(hit1), .rdata_o(rdata1), .rdata_valid_o(rdata_valid1),
    .refill_i(refill_i), .refill_data_i(refill_data_i),
    .icache2mem_addr_o(icache2mem_addr1), .flush_i(flush_i), .flush_busy_o(flush_busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word k of a generated line carries its own line address and word number.
  function automatic logic [31:0] mk_word(input logic [31:0] a);
    return {a[15:4], 4'h0, 14'h0, a[3:2]};
  endfunction

  function automatic logic [127:0] mk_line(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = mk_word({a[31:4], 2'(k), 2'b00});
    return l;
  endfunction

  // Scoreboard: every registered fetch word must match the oldest pending hit.
  always @(negedge clk) begin
    if (rdata_valid_o === 1'b1) begin
      if (exp_q.size() == 0) check("rdata_valid_unexpected", 32'(rdata_valid_o), 32'd0);
      else check("rdata", rdata_o, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] a, input logic [127:0] d);
    addr_i = a; refill_data_i = d; refill_i = 1'b1;
    tick();
    refill_i = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] a, input logic exp_hit, input logic [31:0] exp_word,
                        input logic chk_dm, input logic exp_hit_dm);
    addr_i = a; lookup_req_i = 1'b1;
    @(negedge clk);
    check($sformatf("hit@%h", a), 32'(hit_o), 32'(exp_hit));
    if (exp_hit) exp_q.push_back(exp_word);
    if (chk_dm) check($sformatf("dm_hit@%h", a), 32'(hit1), 32'(exp_hit_dm));
    tick();
    lookup_req_i = 1'b0;
    if (chk_dm) begin
      check($sformatf("dm_rvalid@%h", a), 32'(rdata_valid1), 32'(exp_hit_dm));
      if (exp_hit_dm) check($sformatf("dm_rdata@%h", a), rdata1, exp_word);
    end
  endtask

  // Counts busy cycles (bounded by limit) with a lookup, and optionally refill/flush, held.
  task automatic count_busy(input int limit, input logic disturb, output int n);
    n = 0;
    addr_i = 32'h1048; lookup_req_i = 1'b1;
    refill_data_i = mk_line(32'h1040);
    refill_i = disturb; flush_i = disturb;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (flush_busy_o !== 1'b1) break;
      n++;
      if (i % 16 == 0) begin
        check("hit_during_flush", 32'(hit_o), 32'd0);
        check("dm_busy_during_flush", 32'(flush_busy1), 32'd1);
      end
    end
    lookup_req_i = 1'b0; refill_i = 1'b0; flush_i = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    check("reset_rdata", rdata_o, 32'd0);
    check("reset_rdata_valid", 32'(rdata_valid_o), 32'd0);
    check("reset_busy", 32'(flush_busy_o), 32'd1);
    count_busy(200, 1'b0, n_busy);
    check("reset_busy_cycles", 32'(n_busy), 32'd64);
    lookup(32'h1040, 1'b0, '0, 1'b1, 1'b0);

    // Basic refill and word select
    refill(32'h1040, SPEC_LINE);
    lookup(32'h1048, 1'b1, 32'h33333333, 1'b1, 1'b1);
    lookup(32'h1040, 1'b1, 32'h11111111, 1'b0, 1'b0);
    lookup(32'h104C, 1'b1, 32'h44444444, 1'b0, 1'b0);
    addr_i = 32'h104C;
    #1;
    check("icache2mem_addr", icache2mem_addr_o, 32'h1040);
    check("dm_icache2mem_addr", icache2mem_addr1, 32'h1040);

    // Second line in set 4: both ways hold it, direct-mapped instance evicts
    refill(32'h2040, mk_line(32'h2040));
    lookup(32'h1040, 1'b1, 32'h11111111, 1'b1, 1'b0);
    lookup(32'h2044, 1'b1, mk_word(32'h2044), 1'b1, 1'b1);

    // Round-robin eviction in set 4
    refill(32'h3040, mk_line(32'h3040));
    refill(32'h4040, mk_line(32'h4040));
    lookup(32'h3040, 1'b1, mk_word(32'h3040), 1'b0, 1'b0);
    lookup(32'h4048, 1'b1, mk_word(32'h4048), 1'b0, 1'b0);
    lookup(32'h1040, 1'b0, '0, 1'b0, 1'b0);
    lookup(32'h2040, 1'b0, '0, 1'b0, 1'b0);
    refill(32'h5040, mk_line(32'h5040));
    lookup(32'h5044, 1'b1, mk_word(32'h5044), 1'b0, 1'b0);
    lookup(32'h3040, 1'b0, '0, 1'b0, 1'b0);
    lookup(32'h404C, 1'b1, mk_word(32'h404C), 1'b0, 1'b0);

    // Flush with refill and flush pulses held during the walk
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    count_busy(200, 1'b1, n_busy);
    check("flush_busy_cycles", 32'(n_busy), 32'd64);
    lookup(32'h1048, 1'b0, '0, 1'b1, 1'b0);
    lookup(32'h4040, 1'b0, '0, 1'b0, 1'b0);
    lookup(32'h5040, 1'b0, '0, 1'b0, 1'b0);

    // Pointer cleared by flush: third line evicts way0 (0x1040)
    refill(32'h1040, mk_line(32'h1040));
    refill(32'h2040, mk_line(32'h2040));
    refill(32'h3040, mk_line(32'h3040));
    lookup(32'h1040, 1'b0, '0, 1'b0, 1'b0);
    lookup(32'h2048, 1'b1, mk_word(32'h2048), 1'b0, 1'b0);
    lookup(32'h304C, 1'b1, mk_word(32'h304C), 1'b0, 1'b0);

    // Reset, then same-cycle refill and lookup
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    count_busy(200, 1'b0, n_busy);
    check("rereset_busy_cycles", 32'(n_busy), 32'd64);
    addr_i = 32'h1048; lookup_req_i = 1'b1; refill_i = 1'b1; refill_data_i = mk_line(32'h1040);
    @(negedge clk);
    check("same_cycle_hit", 32'(hit_o), 32'd0);
    tick();
    refill_i = 1'b0;
    @(negedge clk);
    check("next_cycle_hit", 32'(hit_o), 32'd1);
    if (hit_o === 1'b1) exp_q.push_back(mk_word(32'h1048));
    tick();
    lookup_req_i = 1'b0;

    // Reset in the middle of a flush restarts the walk
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    count_busy(30, 1'b0, n_busy);
    check("pre_reset_busy_cycles", 32'(n_busy), 32'd30);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    count_busy(200, 1'b0, n_busy);
    check("restart_busy_cycles", 32'(n_busy), 32'd64);
    lookup(32'h1048, 1'b0, '0, 1'b1, 1'b0);

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
